// File: rtl/pwm_timer.sv
// Multi-channel PWM timer with shared prescaler, double-buffered period/duty.
// Optional PWM_INVERT_EN adds a per-channel POLARITY register at 0x20.
module pwm_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pwm_addr,
  input  logic [31:0]       pwm_wdata,
  input  logic              pwm_we,
  output logic [31:0]       pwm_rdata,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_PSC  = 8'h04;
  localparam logic [7:0] A_PER  = 8'h08;
  localparam logic [7:0] A_STAT = 8'h0C;
`ifdef PWM_INVERT_EN
  localparam logic [7:0] A_POL  = 8'h20;
`endif

  logic [7:0] off;
  assign off = pwm_addr[7:0];

  logic                         en_q, en_d;
  logic [15:0]                  psc_sh_q, psc_sh_d;
  logic [CNT_W-1:0]             per_sh_q, per_sh_d;
  logic [CNT_W-1:0]             per_act_q, per_act_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
  logic [15:0]                  pre_q, pre_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         wrap_q, wrap_d;
  logic [NUM_CH-1:0]            pwm_q, pwm_d;
`ifdef PWM_INVERT_EN
  logic [NUM_CH-1:0]            pol_q, pol_d;
`endif

  logic clr;
  logic tick;
  logic wrap_evt;
  logic cmp;

  logic unused_bits;
  assign unused_bits = ^{pwm_addr[31:8], pwm_wdata[31:16]};

  always_comb begin
    en_d       = en_q;
    psc_sh_d   = psc_sh_q;
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    wrap_d     = wrap_q;
    clr        = 1'b0;
`ifdef PWM_INVERT_EN
    pol_d      = pol_q;
`endif
    if (pwm_we) begin
      case (off)
        A_CTRL: begin
          en_d = pwm_wdata[0];
          clr  = pwm_wdata[1];
        end
        A_PSC:  psc_sh_d = pwm_wdata[15:0];
        A_PER:  per_sh_d = pwm_wdata[CNT_W-1:0];
        A_STAT: if (pwm_wdata[0]) wrap_d = 1'b0;
`ifdef PWM_INVERT_EN
        A_POL:  pol_d = pwm_wdata[NUM_CH-1:0];
`endif
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (off == 8'(16 + 4 * i)) duty_sh_d[i] = pwm_wdata[CNT_W-1:0];
      end
    end

    pre_d      = pre_q;
    cnt_d      = cnt_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    wrap_evt   = 1'b0;
    tick       = (pre_q == psc_sh_q);
    if (!en_q) begin
      pre_d      = '0;
      cnt_d      = '0;
      per_act_d  = per_sh_q;
      duty_act_d = duty_sh_q;
    end else if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (cnt_q == per_act_q) begin
        cnt_d      = '0;
        per_act_d  = per_sh_q;
        duty_act_d = duty_sh_q;
        wrap_evt   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      pre_d = pre_q + 16'd1;
    end
    // a wrap in the same cycle as a W1C keeps the flag set
    if (wrap_evt) wrap_d = 1'b1;

    pwm_d = '0;
    cmp   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp = (cnt_q < duty_act_q[i]);
`ifdef PWM_INVERT_EN
      cmp = cmp ^ pol_q[i];
`endif
      pwm_d[i] = en_q & cmp;
    end
  end

  always_comb begin
    pwm_rdata = '0;
    case (off)
      A_CTRL: pwm_rdata[0] = en_q;
      A_PSC:  pwm_rdata[15:0] = psc_sh_q;
      A_PER:  pwm_rdata[CNT_W-1:0] = per_sh_q;
      A_STAT: begin
        pwm_rdata[0]          = wrap_q;
        pwm_rdata[16 +: CNT_W] = cnt_q;
      end
`ifdef PWM_INVERT_EN
      A_POL:  pwm_rdata[NUM_CH-1:0] = pol_q;
`endif
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (off == 8'(16 + 4 * i)) pwm_rdata[CNT_W-1:0] = duty_sh_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q       <= 1'b0;
      psc_sh_q   <= '0;
      per_sh_q   <= '0;
      per_act_q  <= '0;
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pre_q      <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      pwm_q      <= '0;
`ifdef PWM_INVERT_EN
      pol_q      <= '0;
`endif
    end else begin
      en_q       <= en_d;
      psc_sh_q   <= psc_sh_d;
      per_sh_q   <= per_sh_d;
      per_act_q  <= per_act_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      pwm_q      <= pwm_d;
`ifdef PWM_INVERT_EN
      pol_q      <= pol_d;
`endif
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboard bench for pwm_timer: register map, PWM waveforms, wrap/CLR races.
// Builds with or without PWM_INVERT_EN.
module tb_pwm_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pwm_addr = '0;
  logic [31:0] pwm_wdata = '0;
  logic        pwm_we = 1'b0;
  logic [31:0] pwm_rdata;
  logic [3:0]  pwm_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  pwm_timer #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .pwm_addr(pwm_addr),
    .pwm_wdata(pwm_wdata),
    .pwm_we(pwm_we),
    .pwm_rdata(pwm_rdata),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic wr_now(input logic [7:0] a, input logic [31:0] d);
    pwm_addr  = 32'h2000_0000 | 32'(a);
    pwm_wdata = d;
    pwm_we    = 1'b1;
    @(negedge clk);
    pwm_we    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic rd_now(input logic [7:0] a, input logic [31:0] mask,
                        input logic [31:0] exp, input string tag);
    pwm_addr = 32'h2000_0000 | 32'(a);
    pwm_we   = 1'b0;
    sb_push(tag, exp);
    #1;
    sb_pop(pwm_rdata & mask);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] mask,
                    input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd_now(a, mask, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_step(input int ch, input logic e, input string tag);
    sb_push(tag, 32'(e));
    @(negedge clk);
    sb_pop(32'(pwm_out[ch]));
  endtask

  task automatic wait_cnt(input logic [15:0] v);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      pwm_addr = 32'h2000_000C;
      pwm_we   = 1'b0;
      #1;
      if (pwm_rdata[31:16] == v) found = 1'b1;
    end
    if (!found) chk("wait_cnt", 32'(pwm_rdata[31:16]), 32'(v));
  endtask

  initial begin
    #12 rst = 1'b1;

    for (int a = 0; a <= 'h24; a += 4) rd(8'(a), '1, 32'd0, "rst_rd");
    chk("rst_pwm", 32'(pwm_out), 32'd0);

    wr(8'h08, 32'd9);
    rd(8'h08, '1, 32'd9, "per_rd");
    wr(8'h10, 32'd3);
    rd(8'h10, '1, 32'd3, "duty0_rd");
    wr(8'h00, 32'h2);
    rd(8'h00, '1, 32'd0, "ctrl_clr_rd");
    wr(8'h00, 32'h1);
    pwm_addr = 32'h2000_000C;
    for (int j = 0; j < 20; j++) begin
      sb_push("t1_pwm", 32'((j % 10) < 3));
      sb_push("t1_cnt", 32'((j + 1) % 10));
      sb_push("t1_wrap", 32'(j >= 9));
      @(negedge clk);
      sb_pop(32'(pwm_out[0]));
      sb_pop(32'(pwm_rdata[31:16]));
      sb_pop(32'(pwm_rdata[0]));
    end
    wr(8'h0C, 32'h1);
    rd(8'h0C, 32'h1, 32'd0, "w1c");
    rd(8'h00, '1, 32'd1, "ctrl_en_rd");

    wr(8'h00, 32'h0);
    wr(8'h10, 32'd3);
    wr(8'h00, 32'h1);
    for (int j = 0; j < 4; j++) pwm_step(0, (j % 10) < 3, "t4_old");
    wr(8'h10, 32'd7);
    for (int j = 6; j < 25; j++)
      pwm_step(0, (j % 10) < ((j >= 10) ? 7 : 3), "t4_mid");

    wait_cnt(16'd6);
    wr_now(8'h00, 32'h3);
    rd_now(8'h0C, 32'hFFFF_0000, 32'd0, "clr_cnt");
    rd_now(8'h0C, 32'h1, 32'd1, "clr_wrap_kept");
    wait_cnt(16'd2);
    wr_now(8'h0C, 32'h1);
    rd_now(8'h0C, 32'h1, 32'd0, "w1c2");
    wait_cnt(16'd9);
    wr_now(8'h00, 32'h3);
    rd_now(8'h0C, 32'h1, 32'd0, "clr_at_wrap");
    rd_now(8'h0C, 32'hFFFF_0000, 32'd0, "clr_at_wrap_cnt");
    wait_cnt(16'd9);
    wr_now(8'h0C, 32'h1);
    rd_now(8'h0C, 32'h1, 32'd1, "set_wins");

    wr(8'h00, 32'h0);
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd4);
    wr(8'h14, 32'd5);
    rd(8'h04, '1, 32'd3, "psc_rd");
    wr(8'h00, 32'h1);
    idle(2);
    for (int j = 0; j < 30; j++) pwm_step(1, 1'b1, "t2_high");
    wr(8'h14, 32'd0);
    idle(25);
    for (int j = 0; j < 20; j++) pwm_step(1, 1'b0, "t2_low");

`ifdef PWM_INVERT_EN
    wr(8'h00, 32'h0);
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd9);
    wr(8'h10, 32'd3);
    wr(8'h20, 32'h1);
    rd(8'h20, '1, 32'h1, "pol_rd");
    wr(8'h00, 32'h1);
    for (int j = 0; j < 20; j++) pwm_step(0, !((j % 10) < 3), "inv_pwm");
    wr(8'h00, 32'h0);
    @(negedge clk);
    chk("inv_dis", 32'(pwm_out), 32'd0);
    wr(8'h20, 32'h0);
`else
    wr(8'h20, 32'h1);
    rd(8'h20, '1, 32'd0, "pol_unmapped");
`endif

    wr(8'h00, 32'h0);
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd4);
    wr(8'h10, 32'd100);
    wr(8'h00, 32'h1);
    idle(3);
    chk("pre_arst", 32'(pwm_out[0]), 32'd1);
    #2 rst = 1'b0;
    #1 chk("arst_pwm", 32'(pwm_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rd(8'h00, '1, 32'd0, "arst_ctrl");
    rd(8'h08, '1, 32'd0, "arst_per");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
